// File: rtl/core_memory.sv
// core_memory
//   Memory-side responder for the simple processor core. Holds the
//   instruction RAM and the data RAM. After reset it zeroes the data RAM,
//   accepts a program image over a valid/ready load port, and then pulses
//   `start` once to launch the core. Core reads and writes are honoured
//   only while running.
//
// Ports
//   clock       rising-edge clock shared with the core
//   reset_n     asynchronous active-low reset
//   ld_valid    load word present on ld_data
//   ld_data     instruction word to load
//   ld_last     marks the final load word
//   ld_ready    load port can accept a word
//   pc_in       instruction address from the core (low IADDR_W bits used)
//   ar_in       data address from the core (low DADDR_W bits used)
//   read_en     bit0 = data RAM read, bit1 = instruction RAM read
//   write_en    data RAM write
//   dram_wdata  write data from the core
//   dram_rdata  registered data RAM read data
//   iram_rdata  registered instruction RAM read data
//   start       one-cycle pulse on the first cycle of RUN
//   running     high while in RUN
module core_memory #(
  parameter int DATA_W  = 16,
  parameter int DADDR_W = 9,
  parameter int IADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic [15:0]       pc_in,
  input  logic [15:0]       ar_in,
  input  logic [1:0]        read_en,
  input  logic              write_en,
  input  logic [DATA_W-1:0] dram_wdata,
  output logic [DATA_W-1:0] dram_rdata,
  output logic [DATA_W-1:0] iram_rdata,
  output logic              start,
  output logic              running
);

  localparam int DDEPTH = 1 << DADDR_W;
  localparam int IDEPTH = 1 << IADDR_W;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t               state_q;
  logic [DADDR_W-1:0]   clr_addr_q;
  logic [IADDR_W-1:0]   ld_addr_q;
  logic                 ld_ready_q;
  logic                 start_q;
  logic                 running_q;
  logic [DATA_W-1:0]    dram_rdata_q;
  logic [DATA_W-1:0]    iram_rdata_q;

  logic [DATA_W-1:0]    dram_mem [DDEPTH];
  logic [DATA_W-1:0]    iram_mem [IDEPTH];

  // Single data RAM write port shared by the clear sweep and the core.
  logic                 dram_we_d;
  logic [DADDR_W-1:0]   dram_waddr_d;
  logic [DATA_W-1:0]    dram_wdata_d;

  logic                 load_fire;
  logic [DADDR_W-1:0]   core_daddr;
  logic [IADDR_W-1:0]   core_iaddr;
  logic                 unused_addr_bits;

  // ld_ready_q is high exactly while in LOAD, so this is the transfer qualifier.
  assign load_fire  = ld_valid && ld_ready_q;
  assign core_daddr = ar_in[DADDR_W-1:0];
  assign core_iaddr = pc_in[IADDR_W-1:0];
  // Upper address bits alias onto the low ones by design.
  assign unused_addr_bits = ^{pc_in[15:IADDR_W], ar_in[15:DADDR_W]};

  always_comb begin
    dram_we_d    = 1'b0;
    dram_waddr_d = core_daddr;
    dram_wdata_d = dram_wdata;
    if (state_q == S_CLEAR) begin
      dram_we_d    = 1'b1;
      dram_waddr_d = clr_addr_q;
      dram_wdata_d = '0;
    end else if (running_q && write_en) begin
      dram_we_d    = 1'b1;
    end
  end

  // Sequencer: CLEAR -> LOAD -> RUN, left only by reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_CLEAR;
      clr_addr_q <= '0;
      ld_addr_q  <= '0;
      ld_ready_q <= 1'b0;
      start_q    <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        S_CLEAR: begin
          clr_addr_q <= clr_addr_q + 1'b1;
          if (clr_addr_q == '1) begin
            state_q    <= S_LOAD;
            ld_ready_q <= 1'b1;
          end
        end
        S_LOAD: begin
          if (load_fire) begin
            // The last writable address ends the load; the pointer never wraps.
            if (ld_last || (ld_addr_q == '1)) begin
              state_q    <= S_RUN;
              ld_ready_q <= 1'b0;
              start_q    <= 1'b1;
              running_q  <= 1'b1;
            end else begin
              ld_addr_q <= ld_addr_q + 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (dram_we_d) begin
      dram_mem[dram_waddr_d] <= dram_wdata_d;
    end
  end

  always_ff @(posedge clock) begin
    if (load_fire) begin
      iram_mem[ld_addr_q] <= ld_data;
    end
  end

  // Registered reads; the read of the pre-edge contents gives read-first
  // behaviour when a core write hits the same address in the same cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dram_rdata_q <= '0;
      iram_rdata_q <= '0;
    end else if (running_q) begin
      if (read_en[0]) begin
        dram_rdata_q <= dram_mem[core_daddr];
      end
      if (read_en[1]) begin
        iram_rdata_q <= iram_mem[core_iaddr];
      end
    end
  end

  assign ld_ready   = ld_ready_q;
  assign start      = start_q;
  assign running    = running_q;
  assign dram_rdata = dram_rdata_q;
  assign iram_rdata = iram_rdata_q;

endmodule

// File: tb/tb_core_memory.sv
module tb_core_memory;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ld_valid = 1'b0;
  logic [15:0] ld_data = '0;
  logic        ld_last = 1'b0;
  logic        ld_ready;
  logic [15:0] pc_in = '0;
  logic [15:0] ar_in = '0;
  logic [1:0]  read_en = '0;
  logic        write_en = 1'b0;
  logic [15:0] dram_wdata = '0;
  logic [15:0] dram_rdata;
  logic [15:0] iram_rdata;
  logic        start;
  logic        running;

  core_memory #(.DATA_W(16), .DADDR_W(9), .IADDR_W(8)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .ld_ready   (ld_ready),
    .pc_in      (pc_in),
    .ar_in      (ar_in),
    .read_en    (read_en),
    .write_en   (write_en),
    .dram_wdata (dram_wdata),
    .dram_rdata (dram_rdata),
    .iram_rdata (iram_rdata),
    .start      (start),
    .running    (running)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Reference model: plain memory images plus the last value each read port returned.
  logic [15:0] iram_m [256];
  logic [15:0] dram_m [512];
  logic [15:0] exp_i;
  logic [15:0] exp_d;
  logic [15:0] words [$];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_core();
    read_en    = 2'b00;
    write_en   = 1'b0;
    pc_in      = '0;
    ar_in      = '0;
    dram_wdata = '0;
  endtask

  // Hold reset, check the reset outputs, release, then time the data RAM clear
  // while the core hammers the ports with requests that must be ignored.
  task automatic reset_and_clear();
    int n;
    bit start_seen;
    bit rd_nonzero;
    reset_n  = 1'b0;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    idle_core();
    exp_i = '0;
    exp_d = '0;
    tick();
    chk("rst_ld_ready", {15'd0, ld_ready}, 16'd0);
    chk("rst_start", {15'd0, start}, 16'd0);
    chk("rst_running", {15'd0, running}, 16'd0);
    chk("rst_dram_rdata", dram_rdata, 16'h0000);
    chk("rst_iram_rdata", iram_rdata, 16'h0000);
    reset_n = 1'b1;
    n = 0;
    start_seen = 1'b0;
    rd_nonzero = 1'b0;
    while (!ld_ready && n < 2000) begin
      read_en    = 2'($urandom);
      write_en   = 1'b1;
      ar_in      = 16'($urandom);
      pc_in      = 16'($urandom);
      dram_wdata = 16'hAAAA;
      ld_valid   = 1'($urandom);
      ld_data    = 16'($urandom);
      ld_last    = 1'($urandom);
      tick();
      n++;
      if (start) start_seen = 1'b1;
      if (dram_rdata !== 16'h0 || iram_rdata !== 16'h0) rd_nonzero = 1'b1;
    end
    idle_core();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    chk("clear_cycles", 16'(n), 16'd512);
    chk("clear_no_start", {15'd0, start_seen}, 16'd0);
    chk("clear_rdata_zero", {15'd0, rd_nonzero}, 16'd0);
    for (int i = 0; i < 512; i++) dram_m[i] = '0;
  endtask

  // Stream the queued words; a completed load must end in RUN with one start pulse.
  task automatic load(input logic [15:0] wq [$], input bit use_last, input bit gaps);
    for (int i = 0; i < wq.size(); i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          ld_valid   = 1'b0;
          ld_data    = 16'($urandom);
          ld_last    = 1'($urandom);
          read_en    = 2'b11;
          write_en   = 1'b1;
          ar_in      = 16'd7;
          dram_wdata = 16'hAAAA;
          tick();
        end
      end
      chk("load_ready", {15'd0, ld_ready}, 16'd1);
      chk("load_no_start", {15'd0, start}, 16'd0);
      idle_core();
      ld_valid = 1'b1;
      ld_data  = wq[i];
      ld_last  = use_last && (i == wq.size() - 1);
      tick();
      iram_m[i] = wq[i];
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    chk("load_start", {15'd0, start}, 16'd1);
    chk("load_running", {15'd0, running}, 16'd1);
    chk("load_ready_low", {15'd0, ld_ready}, 16'd0);
    chk("load_dram_rdata_idle", dram_rdata, 16'h0000);
    chk("load_iram_rdata_idle", iram_rdata, 16'h0000);
    tick();
    chk("start_one_cycle", {15'd0, start}, 16'd0);
    chk("still_running", {15'd0, running}, 16'd1);
  endtask

  // One RUN cycle: reads see the pre-edge image, a write lands afterwards.
  task automatic cyc(input string tag, input logic [1:0] re, input logic we,
                     input logic [15:0] pc, input logic [15:0] ar, input logic [15:0] wd);
    read_en    = re;
    write_en   = we;
    pc_in      = pc;
    ar_in      = ar;
    dram_wdata = wd;
    tick();
    if (re[1]) exp_i = iram_m[pc[7:0]];
    if (re[0]) exp_d = dram_m[ar[8:0]];
    if (we) dram_m[ar[8:0]] = wd;
    idle_core();
    chk({tag, "_iram"}, iram_rdata, exp_i);
    chk({tag, "_dram"}, dram_rdata, exp_d);
  endtask

  initial begin
    // Phase 1: clear, short load, fetch, data path and read-first.
    reset_and_clear();
    words = '{16'h1111, 16'h2222, 16'h3333};
    load(words, 1'b1, 1'b0);
    cyc("fetch_pc1", 2'b10, 1'b0, 16'h0001, 16'h0, 16'h0);
    chk("fetch_pc1_value", iram_rdata, 16'h2222);
    cyc("fetch_hold", 2'b00, 1'b0, 16'h0002, 16'h0, 16'h0);
    cyc("fetch_pc2", 2'b10, 1'b0, 16'h0002, 16'h0, 16'h0);
    cyc("fetch_alias", 2'b10, 1'b0, 16'h0101, 16'h0, 16'h0);
    chk("fetch_alias_value", iram_rdata, 16'h2222);
    cyc("wr5", 2'b00, 1'b1, 16'h0, 16'd5, 16'hBEEF);
    cyc("rd5", 2'b01, 1'b0, 16'h0, 16'd5, 16'h0);
    chk("rd5_value", dram_rdata, 16'hBEEF);
    cyc("rw5", 2'b01, 1'b1, 16'h0, 16'd5, 16'h1234);
    chk("read_first_value", dram_rdata, 16'hBEEF);
    cyc("rd5_new", 2'b01, 1'b0, 16'h0, 16'd5, 16'h0);
    chk("rd5_new_value", dram_rdata, 16'h1234);
    cyc("rd300", 2'b01, 1'b0, 16'h0, 16'd300, 16'h0);
    chk("rd300_value", dram_rdata, 16'h0000);

    // Phase 2: reset during RUN, then full-depth random load with gaps.
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_running_drop", {15'd0, running}, 16'd0);
    reset_and_clear();
    words.delete();
    for (int i = 0; i < 256; i++) words.push_back(16'($urandom));
    load(words, 1'b0, 1'b1);
    cyc("rd7_after_load", 2'b01, 1'b0, 16'h0, 16'd7, 16'h0);
    chk("rd7_ignored_write", dram_rdata, 16'h0000);
    cyc("rd5_after_reload", 2'b01, 1'b0, 16'h0, 16'd5, 16'h0);
    chk("rd5_recleared", dram_rdata, 16'h0000);
    for (int i = 0; i < 300; i++) begin
      cyc("rand", 2'($urandom), 1'($urandom), 16'($urandom),
          {7'($urandom), 9'($urandom_range(0, 15))}, 16'($urandom));
    end

    // Phase 3: full-depth load of index values, no ld_last.
    reset_and_clear();
    words.delete();
    for (int i = 0; i < 256; i++) words.push_back(16'(i));
    load(words, 1'b0, 1'b0);
    cyc("full_255", 2'b10, 1'b0, 16'h00FF, 16'h0, 16'h0);
    chk("full_255_value", iram_rdata, 16'h00FF);
    cyc("full_0", 2'b10, 1'b0, 16'h0000, 16'h0, 16'h0);
    chk("full_0_value", iram_rdata, 16'h0000);

    // Phase 4: reset after two load words, then a fresh load from address 0.
    reset_and_clear();
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1;
      ld_data  = 16'hA001 + 16'(i);
      ld_last  = 1'b0;
      tick();
      iram_m[i] = 16'hA001 + 16'(i);
    end
    ld_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("midload_ready_drop", {15'd0, ld_ready}, 16'd0);
    chk("midload_start_low", {15'd0, start}, 16'd0);
    reset_and_clear();
    words = '{16'hC001, 16'hC002, 16'hC003};
    load(words, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc("reload_fetch", 2'b10, 1'b0, 16'(i), 16'h0, 16'h0);
    end
    chk("reload_word3_kept", iram_rdata, 16'h0003);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
